// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit ALU: fetches instruction words, drives the
// registered ALU inputs from an 8x16 register file, then retires into regfile, SR, Hi/Lo or PC.
module alu_issue_ctrl #(
  parameter int unsigned     PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr_data,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     alu_rs,
  output logic [15:0]     alu_rt_cnst,
  output logic [3:0]      alu_opcode,
  output logic [2:0]      alu_shamt,
  input  logic [16:0]     alu_rd,
  output logic [15:0]     sr,
  output logic            retire,
  input  logic [2:0]      dbg_addr,
  output logic [15:0]     dbg_data
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [15:0]     r_instr;
  logic [16:0]     r_res;
  logic [15:0]     r_regs [8];
  logic [7:0]      r_hi;
  logic [7:0]      r_lo;
  logic [15:0]     r_sr;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_aluRs;
  logic [15:0]     r_aluRtCnst;
  logic [3:0]      r_aluOpcode;
  logic [2:0]      r_aluShamt;

  logic [3:0]      w_op;
  logic [2:0]      w_rd;
  logic [2:0]      w_rs;
  logic [2:0]      w_rt;
  logic [15:0]     w_rsVal;
  logic [15:0]     w_rtVal;
  logic [15:0]     w_imm6Ext;
  logic [31:0]     w_imm12Ext;
  logic [15:0]     w_rtCnst;
  logic            w_regWe;
  logic [15:0]     w_regWd;
  logic            w_flagWe;
  logic            w_hiLoWe;
  logic            w_branch;

  assign w_op       = r_instr[15:12];
  assign w_rd       = r_instr[11:9];
  assign w_rs       = r_instr[8:6];
  assign w_rt       = r_instr[5:3];
  assign w_rsVal    = (w_rs == 3'd0) ? 16'h0000 : r_regs[w_rs];
  assign w_rtVal    = (w_rt == 3'd0) ? 16'h0000 : r_regs[w_rt];
  assign w_imm6Ext  = {{10{r_instr[5]}}, r_instr[5:0]};
  assign w_imm12Ext = {{20{r_instr[11]}}, r_instr[11:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:   if (instr_valid) w_nextState = DECODE;
      DECODE:  w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = FETCH;
      default: w_nextState = FETCH;
    endcase
  end

  always_comb begin
    w_rtCnst = 16'h0000;
    case (w_op)
      4'd0, 4'd3, 4'd4, 4'd10, 4'd13: w_rtCnst = w_rtVal;
      4'd5, 4'd6, 4'd7, 4'd8:         w_rtCnst = w_imm6Ext;
      default:                        w_rtCnst = 16'h0000;
    endcase
  end

  // Op 13 tests SR as it stood before this instruction, so its own flags cannot enable it.
  always_comb begin
    w_regWe  = 1'b0;
    w_regWd  = r_res[15:0];
    w_flagWe = 1'b0;
    w_hiLoWe = 1'b0;
    w_branch = 1'b0;
    if (r_state == WB) begin
      case (w_op)
        4'd0, 4'd5, 4'd7, 4'd8: begin
          w_regWe  = 1'b1;
          w_flagWe = 1'b1;
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd6: w_regWe = 1'b1;
        4'd9:  w_branch = 1'b1;
        4'd10: begin
          w_regWe  = 1'b1;
          w_flagWe = 1'b1;
          w_hiLoWe = 1'b1;
        end
        4'd11: begin
          w_regWe = 1'b1;
          w_regWd = {8'h00, r_lo};
        end
        4'd12: begin
          w_regWe = 1'b1;
          w_regWd = {8'h00, r_hi};
        end
        4'd13: begin
          if (r_sr[3] || r_sr[2]) begin
            w_regWe  = 1'b1;
            w_flagWe = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr     <= '0;
      r_res       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_sr        <= '0;
      r_pc        <= RESET_PC;
      r_aluRs     <= '0;
      r_aluRtCnst <= '0;
      r_aluOpcode <= '0;
      r_aluShamt  <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == FETCH && instr_valid) begin
        r_instr <= instr_data;
        r_pc    <= r_pc + PC_W'(1);
      end
      if (r_state == DECODE) begin
        r_aluOpcode <= w_op;
        r_aluShamt  <= r_instr[2:0];
        r_aluRs     <= w_rsVal;
        r_aluRtCnst <= w_rtCnst;
      end
      if (r_state == EXEC) r_res <= alu_rd;
      if (w_regWe && w_rd != 3'd0) r_regs[w_rd] <= w_regWd;
      if (w_flagWe) begin
        r_sr[0] <= r_res[16];
        r_sr[2] <= r_res[15];
        r_sr[3] <= (r_res[15:0] == 16'h0000);
      end
      if (w_hiLoWe) begin
        r_hi <= r_res[15:8];
        r_lo <= r_res[7:0];
      end
      if (w_branch) r_pc <= r_pc + w_imm12Ext[PC_W-1:0];
    end
  end

  assign instr_ready = (r_state == FETCH);
  assign retire      = (r_state == WB);
  assign pc          = r_pc;
  assign sr          = r_sr;
  assign alu_rs      = r_aluRs;
  assign alu_rt_cnst = r_aluRtCnst;
  assign alu_opcode  = r_aluOpcode;
  assign alu_shamt   = r_aluShamt;
  assign dbg_data    = (dbg_addr == 3'd0) ? 16'h0000 : r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a small ALU model closes the loop, a vector table
// drives whole instructions, and hand sequences cover back-pressure and mid-op reset.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [11:0] pc;
  logic [15:0] alu_rs;
  logic [15:0] alu_rt_cnst;
  logic [3:0]  alu_opcode;
  logic [2:0]  alu_shamt;
  logic [16:0] alu_rd;
  logic [15:0] sr;
  logic        retire;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int totalCnt   = 0;
  int badCnt     = 0;
  int retireCnt  = 0;
  int expRetire  = 0;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  dbgAddr;
    logic [15:0] expData;
    logic [15:0] expSr;
    logic [11:0] expPc;
    logic [16:0] expAluRd;
  } vec_t;

  vec_t vecs [25];

  alu_issue_ctrl #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .pc          (pc),
    .alu_rs      (alu_rs),
    .alu_rt_cnst (alu_rt_cnst),
    .alu_opcode  (alu_opcode),
    .alu_shamt   (alu_shamt),
    .alu_rd      (alu_rd),
    .sr          (sr),
    .retire      (retire),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: add/sub/logic, load-immediate pass-through and 16-bit multiply.
  always_comb begin
    logic [31:0] prod;
    prod   = 32'(alu_rs) * 32'(alu_rt_cnst);
    alu_rd = 17'h00000;
    case (alu_opcode)
      4'd0, 4'd5, 4'd13: alu_rd = {1'b0, alu_rs} + {1'b0, alu_rt_cnst};
      4'd1:              alu_rd = {1'b0, alu_rs} - {1'b0, alu_rt_cnst};
      4'd2:              alu_rd = {1'b0, alu_rs & alu_rt_cnst};
      4'd3:              alu_rd = {1'b0, alu_rs | alu_rt_cnst};
      4'd4:              alu_rd = {1'b0, alu_rs ^ alu_rt_cnst};
      4'd6, 4'd7, 4'd8:  alu_rd = {1'b0, alu_rt_cnst};
      4'd10:             alu_rd = {1'b0, prod[15:0]};
      default:           alu_rd = 17'h00000;
    endcase
  end

  always @(negedge clk) if (retire) retireCnt++;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCnt++;
    if (actual !== expected) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Issues one instruction from FETCH and returns at the negedge after its WB.
  task automatic applyStimulus(input int idx);
    int n;
    bit readySeen;
    vec_t v;
    v = vecs[idx];
    n = 0;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("row%0d readyWait", idx), 32'(instr_ready), 32'd1);
    if (!instr_ready) return;
    instr_valid = 1'b1;
    instr_data  = v.instr;
    @(negedge clk);
    instr_valid = 1'b0;
    expRetire++;
    n = 0;
    readySeen = 1'b0;
    while (!retire && n < 8) begin
      readySeen |= instr_ready;
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("row%0d retireLatency", idx), 32'(n), 32'd2);
    checkOutput($sformatf("row%0d readyLowInFlight", idx), 32'(readySeen), 32'd0);
    checkOutput($sformatf("row%0d aluRd", idx), 32'(alu_rd), 32'(v.expAluRd));
    @(negedge clk);
    dbg_addr = v.dbgAddr;
    #1;
    checkOutput($sformatf("row%0d reg r%0d", idx, v.dbgAddr), 32'(dbg_data), 32'(v.expData));
    checkOutput($sformatf("row%0d sr", idx), 32'(sr), 32'(v.expSr));
    checkOutput($sformatf("row%0d pc", idx), 32'(pc), 32'(v.expPc));
  endtask

  initial begin
    int retireSnap;
    logic [11:0] pcSnap;

    vecs[0]  = '{16'h6205, 3'd1, 16'h0005, 16'h0000, 12'h001, 17'h00005};
    vecs[1]  = '{16'h0448, 3'd2, 16'h000A, 16'h0000, 12'h002, 17'h0000A};
    vecs[2]  = '{16'h6207, 3'd1, 16'h0007, 16'h0000, 12'h003, 17'h00007};
    vecs[3]  = '{16'h6406, 3'd2, 16'h0006, 16'h0000, 12'h004, 17'h00006};
    vecs[4]  = '{16'hA650, 3'd3, 16'h002A, 16'h0000, 12'h005, 17'h0002A};
    vecs[5]  = '{16'hB800, 3'd4, 16'h002A, 16'h0000, 12'h006, 17'h00000};
    vecs[6]  = '{16'hCA00, 3'd5, 16'h0000, 16'h0000, 12'h007, 17'h00000};
    vecs[7]  = '{16'h623F, 3'd1, 16'hFFFF, 16'h0000, 12'h008, 17'h0FFFF};
    vecs[8]  = '{16'h6401, 3'd2, 16'h0001, 16'h0000, 12'h009, 17'h00001};
    vecs[9]  = '{16'h0650, 3'd3, 16'h0000, 16'h0009, 12'h00A, 17'h10000};
    vecs[10] = '{16'hD850, 3'd4, 16'h0000, 16'h0009, 12'h00B, 17'h10000};
    vecs[11] = '{16'h6C01, 3'd6, 16'h0001, 16'h0009, 12'h00C, 17'h00001};
    vecs[12] = '{16'h0DB0, 3'd6, 16'h0002, 16'h0000, 12'h00D, 17'h00002};
    vecs[13] = '{16'hDE50, 3'd7, 16'h0000, 16'h0000, 12'h00E, 17'h10000};
    vecs[14] = '{16'h0648, 3'd3, 16'hFFFE, 16'h0005, 12'h00F, 17'h1FFFE};
    vecs[15] = '{16'hDE90, 3'd7, 16'h0002, 16'h0000, 12'h010, 17'h00002};
    vecs[16] = '{16'h0050, 3'd0, 16'h0000, 16'h0009, 12'h011, 17'h10000};
    vecs[17] = '{16'hF000, 3'd0, 16'h0000, 16'h0000, 12'h001, 17'h00000};
    vecs[18] = '{16'hF000, 3'd0, 16'h0000, 16'h0000, 12'h002, 17'h00000};
    vecs[19] = '{16'hF000, 3'd0, 16'h0000, 16'h0000, 12'h003, 17'h00000};
    vecs[20] = '{16'hF000, 3'd0, 16'h0000, 16'h0000, 12'h004, 17'h00000};
    vecs[21] = '{16'hE000, 3'd0, 16'h0000, 16'h0000, 12'h005, 17'h00000};
    vecs[22] = '{16'h9FFE, 3'd0, 16'h0000, 16'h0000, 12'h004, 17'h00000};
    vecs[23] = '{16'h9FFA, 3'd0, 16'h0000, 16'h0000, 12'hFFF, 17'h00000};
    vecs[24] = '{16'hF000, 3'd0, 16'h0000, 16'h0000, 12'h000, 17'h00000};

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 16'h0000;
    dbg_addr    = 3'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset pc", 32'(pc), 32'h000);
    checkOutput("reset sr", 32'(sr), 32'h0000);
    checkOutput("reset retire", 32'(retire), 32'd0);
    checkOutput("reset aluRs", 32'(alu_rs), 32'h0000);
    checkOutput("reset aluOpcode", 32'(alu_opcode), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready after release", 32'(instr_ready), 32'd1);

    for (int i = 0; i <= 15; i++) applyStimulus(i);

    $display("[TB] back-pressure: instr_valid low for 10 cycles");
    retireSnap = retireCnt;
    pcSnap     = pc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d ready", i), 32'(instr_ready), 32'd1);
    end
    checkOutput("idle retireCount", 32'(retireCnt), 32'(retireSnap));
    checkOutput("idle pc", 32'(pc), 32'(pcSnap));

    applyStimulus(16);
    checkOutput("retire total", 32'(retireCnt), 32'(expRetire));

    $display("[TB] reset during EXEC of add r2");
    retireSnap  = retireCnt;
    instr_valid = 1'b1;
    instr_data  = 16'h0448;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset pc", 32'(pc), 32'h000);
    checkOutput("midReset sr", 32'(sr), 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dbg_addr = 3'd2;
    #1;
    checkOutput("midReset ready", 32'(instr_ready), 32'd1);
    checkOutput("midReset r2", 32'(dbg_data), 32'h0000);
    checkOutput("midReset noRetire", 32'(retireCnt), 32'(retireSnap));
    checkOutput("midReset pcAfter", 32'(pc), 32'h000);

    for (int i = 17; i <= 24; i++) applyStimulus(i);
    checkOutput("retire total end", 32'(retireCnt - retireSnap), 32'd8);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle instruction issue and writeback controller on the driving side of the 16-bit ALU datapath.
- Accepts 16-bit instruction words via a valid/ready handshake and decodes them.
- Reads an internal 8x16 register file and drives the ALU operand/opcode/shamt inputs.
- Captures the 17-bit ALU result, then writes back the register, status flags (SR), Hi/Lo and PC.

Parameters:
PC_W, 12, program counter width
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction word on instr_data is valid
instr_ready  output  1  controller can accept an instruction (FETCH state only)
instr_data  input  16  instruction: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] shamt; ops 5-8 use [5:0] imm6; op 9 uses [11:0] imm12
pc  output  PC_W  address of the instruction to present next
alu_rs  output  16  ALU operand Rs (registered)
alu_rt_cnst  output  16  ALU operand Rt or constant (registered)
alu_opcode  output  4  ALU opcode (registered)
alu_shamt  output  3  ALU shift amount (registered)
alu_rd  input  17  ALU result; bit 16 is carry-out
sr  output  16  status register: [0] carry, [2] negative, [3] zero, others 0
retire  output  1  one-cycle pulse when an instruction completes
dbg_addr  input  3  debug register-file read address
dbg_data  output  16  combinational read of regfile[dbg_addr]

Behaviour:
- Reset, asynchronous, while rst_n=0: state=FETCH, pc=RESET_PC, all regfile entries=0, hi=lo=0, sr=0, ALU outputs=0, retire=0. instr_ready=1 on the first cycle after release.
- Reset mid-operation: the in-flight instruction is discarded; no writeback occurs.
- r0 always reads 0. Writes to r0 are dropped, but flags still update.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH. Fixed 4 cycles per instruction. No stalls other than instr_valid.
- FETCH: instr_ready=1. On instr_valid=1, latch instr_data, pc <= pc+1 (wraps modulo 2^PC_W), go to DECODE. While instr_valid=0, stay in FETCH.
- DECODE: register alu_opcode=op, alu_shamt=shamt, alu_rs=R[rs].
  - alu_rt_cnst = R[rt] for ops 0,3,4,10,13.
  - alu_rt_cnst = sign-extended imm6 for ops 5,6,7,8.
  - alu_rt_cnst = 0 otherwise.
- EXEC: latch alu_rd into a 17-bit result register.
- WB: retire=1 for exactly this cycle, then go to FETCH. Per op:
  - ops 0-8, 10: R[rd] <= res[15:0].
  - op 10 additionally: hi <= res[15:8], lo <= res[7:0].
  - op 11: R[rd] <= {8'h00, lo}. op 12: R[rd] <= {8'h00, hi}. The ALU result is ignored for ops 11/12.
  - op 9: pc <= pc + sext(imm12). pc is already incremented, so the branch is relative to the next instruction; wraps. No register write.
  - op 13: write R[rd] <= res[15:0] only if sr[3] or sr[2] was set before this instruction. Otherwise no write. retire still pulses.
  - ops 14, 15: no-op. No writes; retire still pulses.
- Flags: updated in WB only for ops 0,5,7,8,10, and op 13 when executed.
  - sr[0] = res[16]; sr[2] = res[15]; sr[3] = (res[15:0]==0).
  - All other ops leave sr unchanged.
- Read-after-write: the regfile write completes in WB, before the next DECODE, so no forwarding is needed.
- dbg_data reflects a write on the cycle after WB.

Test Plan:
- Load and add: 0x6205 (ldi r1=5), then 0x0448 (add r2=r1+r1) -> r2=0x000A; sr[3:0]=0000; exactly 2 retire pulses; instr_ready high 1 of every 4 cycles.
- Multiply and Hi/Lo: ldi r1=7, ldi r2=6, op10 r3=r1*r2 -> r3=0x002A, hi=0x00, lo=0x2A. Then op11 into r4 -> r4=0x002A; op12 into r5 -> r5=0x0000.
- Carry/zero and conditional: ldi r1=-1 (0xFFFF), ldi r2=1, add r3 -> alu_rd=0x10000, r3=0, sr[0]=1, sr[3]=1. Then op13 r4=r1+r2 -> r4=0 (executed). Then ldi r6=1; add r6=r6+r6 -> 2, clears sr[3]/sr[2]. Then op13 r7 -> r7 unchanged.
- Branch: at pc=5, issue op9 with imm12=0xFFE -> pc=4 after WB. Also at pc=0xFFF, a non-branch instruction wraps pc to 0x000.
- Back-pressure and r0: hold instr_valid=0 for 10 cycles -> remain in FETCH, no retire. Then add with rd=0 -> r0 still reads 0 while sr updates.
- Reset mid-op: assert rst_n=0 during EXEC of add r2 -> r2 unchanged (0), pc=RESET_PC, sr=0, no retire pulse, instr_ready=1 one cycle after release.
